// File: rtl/name_lookup_ctrl.sv
// name_lookup_ctrl: buffers one NDN name, then walks the level BSTs for the longest matched prefix.
// Optional LOOKUP_STATS_EN adds saturating lookup/full-match/hop counters.
module name_lookup_ctrl #(
  parameter int WORD_SIZE       = 64,
  parameter int POINTER_SIZE    = 16,
  parameter int MAX_NAME_LENGTH = 16,
  parameter int MAX_HOPS        = 32,
  parameter int ROOT_ADDR       = 0
) (
  input  logic                                 clk_in,
  input  logic                                 rst_in,
  input  logic                                 name_valid_in,
  output logic                                 name_ready_out,
  input  logic [WORD_SIZE-1:0]                 name_word_in,
  input  logic                                 name_last_in,
  output logic [POINTER_SIZE-1:0]              address_out,
  output logic [WORD_SIZE-1:0]                 lookup_cont_out,
  output logic [$clog2(MAX_NAME_LENGTH)-1:0]   level_sel_out,
  output logic                                 level_req_out,
  input  logic [POINTER_SIZE-1:0]              next_pointer_in,
  input  logic                                 is_match_in,
  input  logic                                 no_child_in,
  output logic                                 result_valid_out,
  input  logic                                 result_ready_in,
  output logic [$clog2(MAX_NAME_LENGTH+1)-1:0] result_len_out,
  output logic [1:0]                           result_status_out,
  output logic                                 busy_out
`ifdef LOOKUP_STATS_EN
  ,
  output logic [31:0]                          stat_lookups_out,
  output logic [31:0]                          stat_full_out,
  output logic [31:0]                          stat_hops_out
`endif
);
  localparam int CW = $clog2(MAX_NAME_LENGTH + 1);
  localparam int LW = $clog2(MAX_NAME_LENGTH);
  localparam int HW = $clog2(MAX_HOPS + 1);
  localparam logic [POINTER_SIZE-1:0] ROOT = POINTER_SIZE'(ROOT_ADDR);
  localparam logic [CW-1:0] MAXN = CW'(MAX_NAME_LENGTH);
  localparam logic [1:0] ST_FULL = 2'd0, ST_PARTIAL = 2'd1, ST_TIMEOUT = 2'd2, ST_OVERFLOW = 2'd3;
  typedef enum logic [2:0] {S_IDLE, S_PROBE, S_WAIT, S_EVAL, S_DONE} state_t;
  state_t state_q, state_d;
  logic [WORD_SIZE-1:0] name_buf [MAX_NAME_LENGTH];
  logic [CW-1:0] cnt_q, idx_q, len_q;
  logic [HW-1:0] hops_q;
  logic [POINTER_SIZE-1:0] addr_q;
  logic [1:0] status_q;
  logic ovf_q;
  logic accept, last_lvl, hop_last, res_take;
  assign accept = name_valid_in && state_q == S_IDLE;
  assign last_lvl = idx_q == cnt_q - CW'(1);
  assign hop_last = hops_q == HW'(MAX_HOPS - 1);
  assign res_take = state_q == S_DONE && result_ready_in;
  assign address_out = addr_q;
  assign lookup_cont_out = name_buf[idx_q[LW-1:0]];
  assign level_sel_out = idx_q[LW-1:0];
  assign result_len_out = len_q;
  assign result_status_out = status_q;
  // state register
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state_q <= S_IDLE;
    else state_q <= state_d;
  end
  // next state and handshake/strobe outputs; a match takes priority over stale no_child/pointer
  always_comb begin
    state_d = state_q;
    name_ready_out = state_q == S_IDLE;
    level_req_out = state_q == S_PROBE;
    result_valid_out = state_q == S_DONE;
    busy_out = state_q != S_IDLE;
    case (state_q)
      S_IDLE:  state_d = name_valid_in && name_last_in ? S_PROBE : S_IDLE;
      S_PROBE: state_d = S_WAIT;
      S_WAIT:  state_d = S_EVAL;
      S_EVAL:  state_d = is_match_in ? (last_lvl ? S_DONE : S_PROBE) :
                         no_child_in ? S_DONE : (hop_last ? S_DONE : S_PROBE);
      S_DONE:  state_d = result_ready_in ? S_IDLE : S_DONE;
      default: state_d = S_IDLE;
    endcase
  end
  // name buffer load, level walk pointers and the held result
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
      idx_q <= '0;
      hops_q <= '0;
      addr_q <= ROOT;
      ovf_q <= 1'b0;
      len_q <= '0;
      status_q <= ST_FULL;
      for (int i = 0; i < MAX_NAME_LENGTH; i++) name_buf[i] <= '0;
    end else begin
      if (accept) begin
        if (cnt_q != MAXN) begin
          name_buf[cnt_q[LW-1:0]] <= name_word_in;
          cnt_q <= cnt_q + CW'(1);
        end else ovf_q <= 1'b1;
        if (name_last_in) begin
          idx_q <= '0;
          addr_q <= ROOT;
          hops_q <= '0;
        end
      end
      if (state_q == S_EVAL) begin
        if (is_match_in) begin
          if (last_lvl) begin
            len_q <= cnt_q;
            status_q <= ovf_q ? ST_OVERFLOW : ST_FULL;
          end else begin
            idx_q <= idx_q + CW'(1);
            addr_q <= ROOT;
            hops_q <= '0;
          end
        end else if (no_child_in) begin
          len_q <= idx_q;
          status_q <= ST_PARTIAL;
        end else begin
          addr_q <= next_pointer_in;
          hops_q <= hops_q + HW'(1);
          if (hop_last) begin
            len_q <= idx_q;
            status_q <= ST_TIMEOUT;
          end
        end
      end
      if (res_take) begin
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end
    end
  end
`ifdef LOOKUP_STATS_EN
  // saturating lookup, full-match and non-matching hop counters
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      stat_lookups_out <= '0;
      stat_full_out <= '0;
      stat_hops_out <= '0;
    end else begin
      if (res_take && stat_lookups_out != '1) stat_lookups_out <= stat_lookups_out + 32'd1;
      if (res_take && status_q == ST_FULL && stat_full_out != '1) stat_full_out <= stat_full_out + 32'd1;
      if (state_q == S_EVAL && !is_match_in && stat_hops_out != '1) stat_hops_out <= stat_hops_out + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_name_lookup_ctrl.sv
// tb_name_lookup_ctrl: directed scoreboard bench for name_lookup_ctrl with a behavioural level BST model
module tb_name_lookup_ctrl;
  localparam logic [15:0] INV = 16'hFFFF;
  localparam logic [63:0] A = 64'h100, B = 64'h200, C = 64'h180, X = 64'h150, D = 64'h10, E = 64'h20;
  logic clk_in = 1'b0, rst_in = 1'b1;
  logic name_valid_in = 1'b0, name_last_in = 1'b0, result_ready_in = 1'b1;
  logic [63:0] name_word_in = '0;
  logic [15:0] next_pointer_in = '0;
  logic is_match_in = 1'b0, no_child_in = 1'b0;
  logic name_ready_out, level_req_out, result_valid_out, busy_out;
  logic [15:0] address_out;
  logic [63:0] lookup_cont_out;
  logic [3:0] level_sel_out;
  logic [4:0] result_len_out;
  logic [1:0] result_status_out;
  int checks = 0, errors = 0;
  logic [83:0] probe_q[$];
  logic [6:0] res_q[$];
  logic [63:0] words [20];
  logic [63:0] key [16][64];
  logic [15:0] lft [16][64];
  logic [15:0] rgt [16][64];
  logic [63:0] m_key;
  logic [15:0] m_ptr;

  name_lookup_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .name_valid_in(name_valid_in), .name_ready_out(name_ready_out),
    .name_word_in(name_word_in), .name_last_in(name_last_in),
    .address_out(address_out), .lookup_cont_out(lookup_cont_out),
    .level_sel_out(level_sel_out), .level_req_out(level_req_out),
    .next_pointer_in(next_pointer_in), .is_match_in(is_match_in), .no_child_in(no_child_in),
    .result_valid_out(result_valid_out), .result_ready_in(result_ready_in),
    .result_len_out(result_len_out), .result_status_out(result_status_out),
    .busy_out(busy_out)
  );

  always #5 clk_in = ~clk_in;

  // level memory: registered one-cycle reply to each probe
  always @(posedge clk_in) begin
    if (level_req_out) begin
      m_key = key[level_sel_out][address_out[5:0]];
      m_ptr = lookup_cont_out < m_key ? lft[level_sel_out][address_out[5:0]] : rgt[level_sel_out][address_out[5:0]];
      is_match_in <= lookup_cont_out == m_key;
      no_child_in <= m_ptr == INV;
      next_pointer_in <= m_ptr;
    end
  end

  task automatic chk(input string nm, input logic [83:0] act, input logic [83:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: pops expected probes and results as the DUT presents them
  always @(negedge clk_in) begin
    if (level_req_out) begin
      if (probe_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL probe_unexpected got lvl %0d addr %0h cont %0h want none", level_sel_out, address_out, lookup_cont_out);
      end else chk("probe", {level_sel_out, address_out, lookup_cont_out}, probe_q.pop_front());
    end
    if (result_valid_out && result_ready_in) begin
      if (res_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL result_unexpected got len %0d status %0d want none", result_len_out, result_status_out);
      end else chk("result", {result_len_out, result_status_out}, res_q.pop_front());
    end
  end

  task automatic clear_levels();
    for (int l = 0; l < 16; l++)
      for (int a = 0; a < 64; a++) begin
        key[l][a] = '0;
        lft[l][a] = INV;
        rgt[l][a] = INV;
      end
  endtask

  task automatic push_probe(input int l, input int a, input logic [63:0] c);
    probe_q.push_back({4'(l), 16'(a), c});
  endtask

  task automatic push_res(input int len, input int st);
    res_q.push_back({5'(len), 2'(st)});
  endtask

  task automatic send_name(input int n);
    int w;
    for (int i = 0; i < n; i++) begin
      name_valid_in = 1'b1;
      name_word_in = words[i];
      name_last_in = i == n - 1;
      w = 0;
      @(negedge clk_in);
      while (!name_ready_out && w < 100) begin
        @(negedge clk_in);
        w++;
      end
      if (w == 100) chk("name_ready_timeout", {83'd0, name_ready_out}, 84'd1);
      @(posedge clk_in);
      #1;
    end
    name_valid_in = 1'b0;
    name_last_in = 1'b0;
  endtask

  task automatic wait_result(input string nm, input int exp_lat);
    int n = 0;
    while (!result_valid_out && n < 300) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk(nm, 84'(n), 84'(exp_lat));
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!name_ready_out && n < 300) begin
      @(posedge clk_in);
      #1;
      n++;
    end
    chk("back_to_idle", {83'd0, name_ready_out}, 84'd1);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_name_ready"}, {83'd0, name_ready_out}, 84'd1);
    chk({nm, "_result_valid"}, {83'd0, result_valid_out}, 84'd0);
    chk({nm, "_level_req"}, {83'd0, level_req_out}, 84'd0);
    chk({nm, "_busy"}, {83'd0, busy_out}, 84'd0);
    chk({nm, "_address"}, 84'(address_out), 84'd0);
    chk({nm, "_level_sel"}, 84'(level_sel_out), 84'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    clear_levels();
    #3;
    reset_checks("reset");
    chk("reset_len_status", {77'd0, result_len_out, result_status_out}, 84'd0);
    chk("reset_cont", 84'(lookup_cont_out), 84'd0);
    @(posedge clk_in);
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    // two-level full match, 6 cycles from last word to result
    key[0][0] = A;
    key[1][0] = B;
    words[0] = A;
    words[1] = B;
    push_probe(0, 0, A);
    push_probe(1, 0, B);
    push_res(2, 0);
    send_name(2);
    wait_result("lat_two_level", 6);
    wait_idle();
    // right-child hop within level 0
    clear_levels();
    key[0][0] = A;
    rgt[0][0] = 16'd5;
    key[0][5] = C;
    words[0] = C;
    push_probe(0, 0, C);
    push_probe(0, 5, C);
    push_res(1, 0);
    send_name(1);
    wait_result("lat_hop", 6);
    wait_idle();
    // level 1 miss with no left child
    clear_levels();
    key[0][0] = A;
    key[1][0] = B;
    words[0] = A;
    words[1] = X;
    push_probe(0, 0, A);
    push_probe(1, 0, X);
    push_res(1, 1);
    send_name(2);
    wait_result("lat_partial", 6);
    wait_idle();
    // 32 non-matching hops in level 0
    clear_levels();
    for (int i = 0; i < 33; i++) begin
      key[0][i] = E;
      lft[0][i] = 16'(i + 1);
    end
    words[0] = D;
    for (int i = 0; i < 32; i++) push_probe(0, i, D);
    push_res(0, 2);
    send_name(1);
    wait_result("lat_timeout", 96);
    wait_idle();
    // 17 words, the last one dropped
    clear_levels();
    for (int i = 0; i < 17; i++) words[i] = 64'h1000 + 64'(i);
    for (int k = 0; k < 16; k++) begin
      key[k][0] = words[k];
      push_probe(k, 0, words[k]);
    end
    push_res(16, 3);
    send_name(17);
    wait_result("lat_overflow", 48);
    wait_idle();
    // consumer stalls for 5 cycles
    clear_levels();
    key[0][0] = A;
    words[0] = A;
    result_ready_in = 1'b0;
    push_probe(0, 0, A);
    push_res(1, 0);
    send_name(1);
    wait_result("lat_single", 3);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_in);
      #1;
      chk("stall_valid", {83'd0, result_valid_out}, 84'd1);
      chk("stall_result", {77'd0, result_len_out, result_status_out}, {77'd0, 5'd1, 2'd0});
      chk("stall_name_ready", {83'd0, name_ready_out}, 84'd0);
    end
    result_ready_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("handshake_valid_drop", {83'd0, result_valid_out}, 84'd0);
    chk("handshake_idle", {83'd0, name_ready_out}, 84'd1);
    // asynchronous reset during the second probe (address 5)
    clear_levels();
    key[0][0] = A;
    rgt[0][0] = 16'd5;
    key[0][5] = C;
    words[0] = C;
    push_probe(0, 0, C);
    push_probe(0, 5, C);
    send_name(1);
    w = 0;
    for (int seen = 0; seen < 2 && w < 100; w++) begin
      @(negedge clk_in);
      if (level_req_out) seen++;
    end
    chk("probe_wait", {83'd0, w < 100}, 84'd1);
    #1 rst_in = 1'b1;
    #1;
    reset_checks("midreset");
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    // recovery after reset
    key[1][0] = B;
    key[0][0] = A;
    words[0] = A;
    words[1] = B;
    push_probe(0, 0, A);
    push_probe(1, 0, B);
    push_res(2, 0);
    send_name(2);
    wait_result("lat_recover", 6);
    wait_idle();
    chk("probe_q_empty", 84'(probe_q.size()), 84'd0);
    chk("res_q_empty", 84'(res_q.size()), 84'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
